lieat_csr_unit: RTL

LIEAT_CSR_UNIT -- requirements
Module: lieat_csr_unit

---
 rtl/lieat_csr_unit.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/lieat_csr_unit.sv
// Machine-mode CSR file with interrupt/ecall/mret trap sequencing.
// Optional feature macro: LIEAT_CSR_COUNTER_EN adds 64-bit mcycle/minstret.
module lieat_csr_unit #(
   parameter int unsigned    XLEN      = 32,
   parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             csr_ena,
   input  logic             csr_read,
   input  logic             csr_write,
   input  logic [11:0]      csr_idx,
   input  logic [XLEN-1:0]  csr_wdata,
   output logic [XLEN-1:0]  csr_rdata,
   output logic             csr_ilgl,
   input  logic [XLEN-1:0]  csr_pc,
   input  logic [XLEN-1:0]  if_hold_pc,
   input  logic             if_hold_rsp,
   input  logic             trap_ecall,
   input  logic             trap_mret,
   input  logic             irq_msip,
   input  logic             irq_mtip,
   input  logic             instr_retire,
   output logic             trap_take,
   output logic [XLEN-1:0]  trap_pc
);

   localparam int unsigned CSR_AW = 12;
   localparam int unsigned CNT_W  = 64;

   localparam logic [CSR_AW-1:0] ADDR_MSTATUS  = 12'h300;
   localparam logic [CSR_AW-1:0] ADDR_MIE      = 12'h304;
   localparam logic [CSR_AW-1:0] ADDR_MTVEC    = 12'h305;
   localparam logic [CSR_AW-1:0] ADDR_MSCRATCH = 12'h340;
   localparam logic [CSR_AW-1:0] ADDR_MEPC     = 12'h341;
   localparam logic [CSR_AW-1:0] ADDR_MCAUSE   = 12'h342;
   localparam logic [CSR_AW-1:0] ADDR_MTVAL    = 12'h343;
   localparam logic [CSR_AW-1:0] ADDR_MIP      = 12'h344;
`ifdef LIEAT_CSR_COUNTER_EN
   localparam logic [CSR_AW-1:0] ADDR_MCYCLE    = 12'hB00;
   localparam logic [CSR_AW-1:0] ADDR_MINSTRET  = 12'hB02;
   localparam logic [CSR_AW-1:0] ADDR_MCYCLEH   = 12'hB80;
   localparam logic [CSR_AW-1:0] ADDR_MINSTRETH = 12'hB82;
`endif

   localparam logic [XLEN-1:0] ALIGN_MASK  = {{(XLEN-2){1'b1}}, 2'b00};
   localparam logic [XLEN-1:0] CAUSE_MSI   = {1'b1, (XLEN-1)'(3)};
   localparam logic [XLEN-1:0] CAUSE_MTI   = {1'b1, (XLEN-1)'(7)};
   localparam logic [XLEN-1:0] CAUSE_ECALL = XLEN'(11);

   logic            mst_mie_q, mst_mpie_q;
   logic [XLEN-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
   logic            mip_msip_q, mip_mtip_q;

   logic            hit;
   logic [XLEN-1:0] rd_val;
   logic [XLEN-1:0] mstatus_rd, mip_rd;
   logic            wr_en;
   logic            take_sw, take_tm, take_ecall, take_mret, take_trap;
   logic [XLEN-1:0] mtvec_base, pc_plus4;

`ifdef LIEAT_CSR_COUNTER_EN
   logic [CNT_W-1:0] mcycle_q, minstret_q, wdata64;
   logic             we_cyc_lo, we_cyc_hi, we_ret_lo, we_ret_hi;
`else
   logic             unused_retire;
   assign unused_retire = instr_retire;
`endif

   // Address decode and read mux for implemented CSRs
   always_comb begin
      hit        = 1'b0;
      rd_val     = '0;
      mstatus_rd = '0;
      mstatus_rd[12:11] = 2'b11;
      mstatus_rd[7]     = mst_mpie_q;
      mstatus_rd[3]     = mst_mie_q;
      mip_rd     = '0;
      mip_rd[7]  = mip_mtip_q;
      mip_rd[3]  = mip_msip_q;
      case (csr_idx)
         ADDR_MSTATUS:  begin hit = 1'b1; rd_val = mstatus_rd; end
         ADDR_MIE:      begin hit = 1'b1; rd_val = mie_q;      end
         ADDR_MTVEC:    begin hit = 1'b1; rd_val = mtvec_q;    end
         ADDR_MSCRATCH: begin hit = 1'b1; rd_val = mscratch_q; end
         ADDR_MEPC:     begin hit = 1'b1; rd_val = mepc_q;     end
         ADDR_MCAUSE:   begin hit = 1'b1; rd_val = mcause_q;   end
         ADDR_MTVAL:    begin hit = 1'b1; rd_val = mtval_q;    end
         ADDR_MIP:      begin hit = 1'b1; rd_val = mip_rd;     end
`ifdef LIEAT_CSR_COUNTER_EN
         ADDR_MCYCLE:   begin hit = 1'b1; rd_val = XLEN'(mcycle_q);   end
         ADDR_MINSTRET: begin hit = 1'b1; rd_val = XLEN'(minstret_q); end
         ADDR_MCYCLEH: begin
            if (XLEN == 32) begin
               hit    = 1'b1;
               rd_val = XLEN'(mcycle_q[CNT_W-1:32]);
            end
         end
         ADDR_MINSTRETH: begin
            if (XLEN == 32) begin
               hit    = 1'b1;
               rd_val = XLEN'(minstret_q[CNT_W-1:32]);
            end
         end
`endif
         default: begin hit = 1'b0; rd_val = '0; end
      endcase
   end

   assign csr_rdata = (csr_ena && csr_read && hit) ? rd_val : '0;
   assign csr_ilgl  = csr_ena && (csr_read || csr_write) && !hit;
   assign wr_en     = csr_ena && csr_write && hit;

   // Trap arbitration: software irq > timer irq > ecall > mret
   always_comb begin
      take_sw    = mst_mie_q && mie_q[3] && mip_msip_q;
      take_tm    = !take_sw && mst_mie_q && mie_q[7] && mip_mtip_q && if_hold_rsp;
      take_ecall = !take_sw && !take_tm && trap_ecall;
      take_mret  = !take_sw && !take_tm && !trap_ecall && trap_mret;
      take_trap  = take_sw || take_tm || take_ecall;
      mtvec_base = mtvec_q & ALIGN_MASK;
      pc_plus4   = csr_pc + XLEN'(4);
      trap_take  = reset && (take_trap || take_mret);
      trap_pc    = MTVEC_RST;
      if (reset) begin
         if (take_mret)
            trap_pc = mepc_q;
         else if (mtvec_q[1:0] == 2'b01 && take_sw)
            trap_pc = mtvec_base + XLEN'(12);
         else if (mtvec_q[1:0] == 2'b01 && take_tm)
            trap_pc = mtvec_base + XLEN'(28);
         else
            trap_pc = mtvec_base;
      end
   end

   // mstatus: trap/mret updates take priority over software writes
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mst_mie_q  <= 1'b0;
         mst_mpie_q <= 1'b0;
      end else if (take_trap) begin
         mst_mpie_q <= mst_mie_q;
         mst_mie_q  <= 1'b0;
      end else if (take_mret) begin
         mst_mie_q  <= mst_mpie_q;
         mst_mpie_q <= 1'b1;
      end else if (wr_en && csr_idx == ADDR_MSTATUS) begin
         mst_mie_q  <= csr_wdata[3];
         mst_mpie_q <= csr_wdata[7];
      end
   end

   // Trap-state CSRs: mepc, mcause, mtval
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mepc_q   <= '0;
         mcause_q <= '0;
         mtval_q  <= '0;
      end else if (take_trap) begin
         mtval_q <= '0;
         if (take_sw) begin
            mepc_q   <= pc_plus4 & ALIGN_MASK;
            mcause_q <= CAUSE_MSI;
         end else if (take_tm) begin
            mepc_q   <= if_hold_pc & ALIGN_MASK;
            mcause_q <= CAUSE_MTI;
         end else begin
            mepc_q   <= csr_pc & ALIGN_MASK;
            mcause_q <= CAUSE_ECALL;
         end
      end else if (wr_en) begin
         if (csr_idx == ADDR_MEPC)   mepc_q   <= csr_wdata & ALIGN_MASK;
         if (csr_idx == ADDR_MCAUSE) mcause_q <= csr_wdata;
         if (csr_idx == ADDR_MTVAL)  mtval_q  <= csr_wdata;
      end
   end

   // Plain software-writable CSRs; mtvec mode legalised to direct/vectored
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mie_q      <= '0;
         mtvec_q    <= MTVEC_RST;
         mscratch_q <= '0;
      end else if (wr_en) begin
         if (csr_idx == ADDR_MIE)      mie_q      <= csr_wdata;
         if (csr_idx == ADDR_MSCRATCH) mscratch_q <= csr_wdata;
         if (csr_idx == ADDR_MTVEC)
            mtvec_q <= (csr_wdata & ALIGN_MASK) |
                       (csr_wdata[1] ? XLEN'(0) : XLEN'(csr_wdata[0]));
      end
   end

   // mip mirrors the interrupt lines one cycle late
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         mip_msip_q <= 1'b0;
         mip_mtip_q <= 1'b0;
      end else begin
         mip_msip_q <= irq_msip;
         mip_mtip_q <= irq_mtip;
      end
   end

`ifdef LIEAT_CSR_COUNTER_EN
   always_comb begin
      wdata64   = CNT_W'(csr_wdata);
      we_cyc_lo = wr_en && csr_idx == ADDR_MCYCLE;
      we_cyc_hi = wr_en && csr_idx == ADDR_MCYCLEH;
      we_ret_lo = wr_en && csr_idx == ADDR_MINSTRET;
      we_ret_hi = wr_en && csr_idx == ADDR_MINSTRETH;
   end

   // mcycle counts every cycle unless software overwrites a half
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         mcycle_q <= '0;
      else if (we_cyc_lo)
         mcycle_q <= (XLEN == 64) ? wdata64 : {mcycle_q[CNT_W-1:32], wdata64[31:0]};
      else if (we_cyc_hi)
         mcycle_q <= {wdata64[31:0], mcycle_q[31:0]};
      else
         mcycle_q <= mcycle_q + CNT_W'(1);
   end

   // minstret counts retired instructions unless software overwrites a half
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         minstret_q <= '0;
      else if (we_ret_lo)
         minstret_q <= (XLEN == 64) ? wdata64 : {minstret_q[CNT_W-1:32], wdata64[31:0]};
      else if (we_ret_hi)
         minstret_q <= {wdata64[31:0], minstret_q[31:0]};
      else if (instr_retire)
         minstret_q <= minstret_q + CNT_W'(1);
   end
`endif

endmodule
